// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, instruction class
// enum, IF/ID buffer depth and the buffered fetch entry layout.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned OPC_W      = 7;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;   // holds 0..FIFO_DEPTH

   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ITYPE_R       = 4'd0,
      ITYPE_I_ALU   = 4'd1,
      ITYPE_LOAD    = 4'd2,
      ITYPE_JALR    = 4'd3,
      ITYPE_STORE   = 4'd4,
      ITYPE_BRANCH  = 4'd5,
      ITYPE_LUI     = 4'd6,
      ITYPE_AUIPC   = 4'd7,
      ITYPE_JAL     = 4'd8,
      ITYPE_SYSTEM  = 4'd9,
      ITYPE_ILLEGAL = 4'd10
   } itype_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier, shared by the IF/ID buffer and the decoder.
//   opcode  : instr[6:0]
//   itype   : instruction class
//   illegal : opcode is not one of the supported classes
module opcode_classify
   import riscv_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output itype_e           itype,
   output logic             illegal
);

   always_comb begin
      itype = ITYPE_ILLEGAL;
      unique case (opcode)
         OPC_OP:     itype = ITYPE_R;
         OPC_OP_IMM: itype = ITYPE_I_ALU;
         OPC_LOAD:   itype = ITYPE_LOAD;
         OPC_JALR:   itype = ITYPE_JALR;
         OPC_STORE:  itype = ITYPE_STORE;
         OPC_BRANCH: itype = ITYPE_BRANCH;
         OPC_LUI:    itype = ITYPE_LUI;
         OPC_AUIPC:  itype = ITYPE_AUIPC;
         OPC_JAL:    itype = ITYPE_JAL;
         OPC_SYSTEM: itype = ITYPE_SYSTEM;
         default:    itype = ITYPE_ILLEGAL;
      endcase
   end

   assign illegal = (itype == ITYPE_ILLEGAL);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline buffer: 2-entry in-order FIFO between fetch and decode.
// Head entry fields are split out combinationally for the decoder and the
// immediate extender.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop all buffered instructions (redirect)
//   in_valid/in_ready   : fetch handshake, in_instr/in_pc payload
//   out_valid/out_ready : decode handshake, out_pc plus head fields
//   itype/illegal       : class of the head instruction
module if_id_stage
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [11:0]     i_imm12,
   output logic [6:0]      s_hi7,
   output logic [6:0]      b_hi7,
   output logic [4:0]      s_lo5,
   output logic [4:0]      b_lo5,
   output logic [19:0]     uj_imm20,
   output logic [4:0]      csr_uimm5,
   output itype_e          itype,
   output logic            illegal
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   fetch_entry_t     mem_q [FIFO_DEPTH];
   fetch_entry_t     mem_d [FIFO_DEPTH];
   fetch_entry_t     head;
   logic             push, pop;

   // Ready depends only on occupancy, never on out_ready.
   assign in_ready  = (count_q < CNT_W'(FIFO_DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next-state: flush wins over any same-cycle push/pop.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset also clears storage so the head reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q    <= '{default: '0};
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   // Head field extraction straight from storage.
   assign head      = mem_q[rd_ptr_q];
   assign out_pc    = head.pc;
   assign opcode    = head.instr[6:0];
   assign rd        = head.instr[11:7];
   assign funct3    = head.instr[14:12];
   assign rs1       = head.instr[19:15];
   assign rs2       = head.instr[24:20];
   assign funct7    = head.instr[31:25];
   assign i_imm12   = head.instr[31:20];
   assign s_hi7     = head.instr[31:25];
   assign b_hi7     = head.instr[31:25];
   assign s_lo5     = head.instr[11:7];
   assign b_lo5     = head.instr[11:7];
   assign uj_imm20  = head.instr[31:12];
   assign csr_uimm5 = head.instr[19:15];

   opcode_classify u_classify (
      .opcode  (head.instr[6:0]),
      .itype   (itype),
      .illegal (illegal)
   );

endmodule
